log_capture_ctrl: RTL and testbench

- Sequences one capture-and-readout cycle of the equalizer logging block RAM.
- Sits between the register file (command/status over GPIO) and the block RAM controller (write enable, write address, source select, read enable, read address).
- A capture runs as follows:
  - Arm on a start command.
  - Wait N_DELAY cycles so the equalizer settles.
  - Write one word per rate strobe until the RAM is full.
  - Allow host readout once the RAM is full.

---
 rtl/log_capture_ctrl_if.sv | 38 +++
 rtl/log_capture_ctrl.sv | 142 ++++++++++++++
 tb/tb_log_capture_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/log_capture_ctrl_if.sv
// Command, status and block RAM controller signals of the
// equalizer log capture sequencer.
interface log_capture_ctrl_if #(
    parameter int RAM_DEPTH = 32768,
    parameter int NBT_SEL   = 3
);
    localparam int ADDR_W = $clog2(RAM_DEPTH);

    logic               i_start;
    logic               i_abort;
    logic [NBT_SEL-1:0] i_data_sel;
    logic               i_rate_strobe;
    logic               i_rd_req;
    logic [ADDR_W-1:0]  i_rd_adrs;
    logic               o_wr_en;
    logic [ADDR_W-1:0]  o_wr_adrs;
    logic [NBT_SEL-1:0] o_data_sel;
    logic               o_rd_en;
    logic [ADDR_W-1:0]  o_rd_adrs;
    logic               o_rd_valid;
    logic               o_busy;
    logic               o_done;
    logic [ADDR_W:0]    o_wr_count;

    modport master (
        input  i_start, i_abort, i_data_sel, i_rate_strobe,
        input  i_rd_req, i_rd_adrs,
        output o_wr_en, o_wr_adrs, o_data_sel, o_rd_en,
        output o_rd_adrs, o_rd_valid, o_busy, o_done, o_wr_count
    );

    modport slave (
        output i_start, i_abort, i_data_sel, i_rate_strobe,
        output i_rd_req, i_rd_adrs,
        input  o_wr_en, o_wr_adrs, o_data_sel, o_rd_en,
        input  o_rd_adrs, o_rd_valid, o_busy, o_done, o_wr_count
    );
endinterface

// File: rtl/log_capture_ctrl.sv
// Sequences one arm / settle / capture / readout cycle of the
// equalizer logging block RAM.
module log_capture_ctrl #(
    parameter int RAM_DEPTH = 32768,
    parameter int N_DELAY   = 500,
    parameter int NBT_SEL   = 3
) (
    input logic clk,
    input logic i_reset,
    log_capture_ctrl_if.master bus
);
    localparam int ADDR_W = $clog2(RAM_DEPTH);
    localparam int DLY_W  = (N_DELAY > 1) ? $clog2(N_DELAY) : 1;
    localparam logic [ADDR_W:0] LAST =
        (ADDR_W+1)'(RAM_DEPTH - 1);
    localparam logic [DLY_W-1:0] DLY_LAST =
        DLY_W'((N_DELAY > 0) ? N_DELAY - 1 : 0);

    typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, DONE} state_t;

    state_t state_q, state_n;

    logic               start_arm_q;
    logic [DLY_W-1:0]   dly_q, dly_n;
    logic               wr_en_q, wr_en_n;
    logic [ADDR_W-1:0]  wr_adrs_q, wr_adrs_n;
    logic [NBT_SEL-1:0] sel_q, sel_n;
    logic               rd_en_q, rd_en_n;
    logic [ADDR_W-1:0]  rd_adrs_q, rd_adrs_n;
    logic               rd_valid_q, rd_valid_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic [ADDR_W:0]    cnt_q, cnt_n;

    logic start_edge;
    logic can_arm;

    // The start history only arms after i_start has been seen low,
    // so a level held high across reset release is not a command.
    assign start_edge = bus.i_start & start_arm_q;
    assign can_arm    = (state_q == IDLE) || (state_q == DONE);

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        if (bus.i_abort) begin
            state_n = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_edge)
                        state_n = (N_DELAY == 0) ? CAPTURE : DELAY;
                end
                DELAY: begin
                    if (dly_q == DLY_LAST)
                        state_n = CAPTURE;
                end
                CAPTURE: begin
                    if (bus.i_rate_strobe && cnt_q == LAST)
                        state_n = DONE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en_n    = 1'b0;
        wr_adrs_n  = wr_adrs_q;
        sel_n      = sel_q;
        cnt_n      = cnt_q;
        dly_n      = dly_q;
        rd_en_n    = 1'b0;
        rd_adrs_n  = rd_adrs_q;
        rd_valid_n = rd_en_q;
        if (!bus.i_abort) begin
            if (can_arm && start_edge) begin
                sel_n = bus.i_data_sel;
                cnt_n = '0;
                dly_n = '0;
            end
            if (state_q == DELAY)
                dly_n = dly_q + 1'b1;
            if (state_q == CAPTURE && bus.i_rate_strobe) begin
                wr_en_n   = 1'b1;
                wr_adrs_n = cnt_q[ADDR_W-1:0];
                cnt_n     = cnt_q + 1'b1;
            end
        end
        if (can_arm && bus.i_rd_req) begin
            rd_en_n   = 1'b1;
            rd_adrs_n = bus.i_rd_adrs;
        end
        busy_n = (state_n == DELAY) || (state_n == CAPTURE);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            start_arm_q <= 1'b0;
            dly_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_adrs_q   <= '0;
            sel_q       <= '0;
            rd_en_q     <= 1'b0;
            rd_adrs_q   <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            start_arm_q <= ~bus.i_start;
            dly_q       <= dly_n;
            wr_en_q     <= wr_en_n;
            wr_adrs_q   <= wr_adrs_n;
            sel_q       <= sel_n;
            rd_en_q     <= rd_en_n;
            rd_adrs_q   <= rd_adrs_n;
            rd_valid_q  <= rd_valid_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            cnt_q       <= cnt_n;
        end
    end

    assign bus.o_wr_en    = wr_en_q;
    assign bus.o_wr_adrs  = wr_adrs_q;
    assign bus.o_data_sel = sel_q;
    assign bus.o_rd_en    = rd_en_q;
    assign bus.o_rd_adrs  = rd_adrs_q;
    assign bus.o_rd_valid = rd_valid_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_wr_count = cnt_q;
endmodule

// File: tb/tb_log_capture_ctrl.sv
// Directed bench: one DUT with a 4-cycle settle, one with none,
// both on a 16-word RAM.
module tb_log_capture_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    log_capture_ctrl_if #(.RAM_DEPTH(16), .NBT_SEL(3)) b0 ();
    log_capture_ctrl_if #(.RAM_DEPTH(16), .NBT_SEL(3)) b1 ();

    log_capture_ctrl #(
        .RAM_DEPTH(16), .N_DELAY(4), .NBT_SEL(3)
    ) u_dut (
        .clk(clk), .i_reset(rst_n), .bus(b0.master)
    );

    log_capture_ctrl #(
        .RAM_DEPTH(16), .N_DELAY(0), .NBT_SEL(3)
    ) u_dut0 (
        .clk(clk), .i_reset(rst_n), .bus(b1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        b0.i_start = 1'b1; b0.i_abort = 1'b0;
        b0.i_data_sel = 3'd5; b0.i_rate_strobe = 1'b0;
        b0.i_rd_req = 1'b0; b0.i_rd_adrs = '0;
        b1.i_start = 1'b1; b1.i_abort = 1'b0;
        b1.i_data_sel = 3'd1; b1.i_rate_strobe = 1'b1;
        b1.i_rd_req = 1'b0; b1.i_rd_adrs = '0;

        // Reset with start held high
        #22;
        chk("rst_busy", b0.o_busy, 0);
        chk("rst_wr_en", b0.o_wr_en, 0);
        chk("rst_count", b0.o_wr_count, 0);
        chk("rst_sel", b0.o_data_sel, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("held_busy", b0.o_busy, 0);
        end
        chk("held_busy0", b1.o_busy, 0);
        chk("held_wr0", b1.o_wr_en, 0);

        // Edge starts DELAY
        b0.i_start = 1'b0;
        step();
        b0.i_start = 1'b1;
        step();
        chk("start_busy", b0.o_busy, 1);
        chk("start_sel", b0.o_data_sel, 5);
        b0.i_rate_strobe = 1'b1;
        step();
        chk("dly_strobe", b0.o_wr_en, 0);
        b0.i_rate_strobe = 1'b0;
        step();
        step();
        b0.i_rate_strobe = 1'b1;
        step();
        chk("last_dly", b0.o_wr_en, 0);
        step();
        chk("first_wr", b0.o_wr_en, 1);
        chk("first_adrs", b0.o_wr_adrs, 0);
        chk("first_cnt", b0.o_wr_count, 1);

        // One strobe every third clock; 17th must not write
        for (int k = 1; k < 17; k++) begin
            b0.i_rate_strobe = 1'b0;
            step();
            chk("gap_wr", b0.o_wr_en, 0);
            step();
            b0.i_rate_strobe = 1'b1;
            step();
            if (k < 16) begin
                chk("wr_en", b0.o_wr_en, 1);
                chk("wr_adrs", b0.o_wr_adrs, k);
                chk("wr_cnt", b0.o_wr_count, k + 1);
                chk("wr_done", b0.o_done, (k == 15) ? 1 : 0);
            end else begin
                chk("extra_wr", b0.o_wr_en, 0);
                chk("full_cnt", b0.o_wr_count, 16);
                chk("full_adrs", b0.o_wr_adrs, 15);
                chk("full_done", b0.o_done, 1);
            end
            chk("cap_sel", b0.o_data_sel, 5);
        end
        b0.i_rate_strobe = 1'b0;

        // Back-to-back reads in DONE
        b0.i_rd_req = 1'b1; b0.i_rd_adrs = 4'd2;
        step();
        chk("rd1_en", b0.o_rd_en, 1);
        chk("rd1_adrs", b0.o_rd_adrs, 2);
        chk("rd1_vld", b0.o_rd_valid, 0);
        b0.i_rd_adrs = 4'd9;
        step();
        chk("rd2_en", b0.o_rd_en, 1);
        chk("rd2_adrs", b0.o_rd_adrs, 9);
        chk("rd2_vld", b0.o_rd_valid, 1);
        b0.i_rd_adrs = 4'd15;
        step();
        chk("rd3_en", b0.o_rd_en, 1);
        chk("rd3_adrs", b0.o_rd_adrs, 15);
        chk("rd3_vld", b0.o_rd_valid, 1);
        chk("rd3_wr", b0.o_wr_en, 0);
        b0.i_rd_req = 1'b0;
        step();
        chk("rd4_en", b0.o_rd_en, 0);
        chk("rd4_vld", b0.o_rd_valid, 1);
        chk("rd4_hold", b0.o_rd_adrs, 15);
        step();
        chk("rd5_vld", b0.o_rd_valid, 0);

        // Re-arm from DONE, abort after seven writes
        b0.i_start = 1'b0;
        step();
        b0.i_start = 1'b1;
        b0.i_data_sel = 3'd2;
        step();
        chk("rearm_done", b0.o_done, 0);
        chk("rearm_busy", b0.o_busy, 1);
        chk("rearm_cnt", b0.o_wr_count, 0);
        chk("rearm_sel", b0.o_data_sel, 2);
        step(); step(); step(); step();
        b0.i_rate_strobe = 1'b1;
        b0.i_data_sel = 3'd6;
        b0.i_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k == 3) b0.i_start = 1'b1;
            step();
            chk("ab_wr", b0.o_wr_en, 1);
            chk("ab_adrs", b0.o_wr_adrs, k);
        end
        chk("ab_sel", b0.o_data_sel, 2);
        b0.i_abort = 1'b1;
        step();
        chk("ab_no_wr", b0.o_wr_en, 0);
        chk("ab_cnt", b0.o_wr_count, 7);
        chk("ab_busy", b0.o_busy, 0);
        chk("ab_done", b0.o_done, 0);
        b0.i_abort = 1'b0;
        b0.i_rate_strobe = 1'b0;
        b0.i_start = 1'b0;
        step();
        b0.i_start = 1'b1;
        step();
        chk("re_cnt", b0.o_wr_count, 0);
        chk("re_busy", b0.o_busy, 1);
        step(); step(); step(); step();

        // Reads dropped during CAPTURE
        b0.i_rate_strobe = 1'b1;
        b0.i_rd_req = 1'b1;
        b0.i_rd_adrs = 4'd3;
        step();
        chk("re_wr", b0.o_wr_en, 1);
        chk("re_adrs", b0.o_wr_adrs, 0);
        chk("cap_rd_en", b0.o_rd_en, 0);
        b0.i_rd_req = 1'b0;
        step();
        chk("cap_rd_vld", b0.o_rd_valid, 0);
        chk("cap_wr2", b0.o_wr_en, 1);
        chk("cap_cnt2", b0.o_wr_count, 2);

        // Asynchronous reset while a write is on the bus
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr", b0.o_wr_en, 0);
        chk("arst_busy", b0.o_busy, 0);
        chk("arst_cnt", b0.o_wr_count, 0);
        b0.i_rate_strobe = 1'b0;
        b0.i_start = 1'b0;
        #3;
        rst_n = 1'b1;

        // Zero settle, strobe tied high
        step();
        b1.i_start = 1'b0;
        step();
        b1.i_start = 1'b1;
        step();
        chk("z_busy", b1.o_busy, 1);
        chk("z_wr0", b1.o_wr_en, 0);
        for (int k = 0; k < 16; k++) begin
            step();
            chk("z_wr", b1.o_wr_en, 1);
            chk("z_adrs", b1.o_wr_adrs, k);
            chk("z_done", b1.o_done, (k == 15) ? 1 : 0);
        end
        step();
        chk("z_end_wr", b1.o_wr_en, 0);
        chk("z_end_cnt", b1.o_wr_count, 16);
        chk("z_end_done", b1.o_done, 1);
        chk("z_end_busy", b1.o_busy, 0);
        chk("z_sel", b1.o_data_sel, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
